// File: rtl/out32bit_uart_tx_if.sv
// Write-side bundle between the out32bit register strobe and the UART transmitter:
// the word strobe going in, and the FIFO/serialiser status coming back.
interface out32bit_uart_tx_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        fifo_full;
   logic        overflow;
   logic        busy;

   modport master (
      output in_valid,
      output in_data,
      input  fifo_full,
      input  overflow,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output fifo_full,
      output overflow,
      output busy
   );
endinterface

// File: rtl/out32bit_uart_tx.sv
// Buffers words written to the FISMOS out32bit register and sends each one as four
// 8N1 UART frames, least-significant byte first, so firmware never stalls on the line.
module out32bit_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   out32bit_uart_tx_if.slave bus,
   output logic              tx
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } TxState;

   logic [31:0]        fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W:0]     count;
   logic [PTR_W:0]     countNext;
   logic               fifoFullReg;
   logic               overflowReg;
   logic               fifoEmpty;
   logic               pushNow;
   logic               popNow;
   logic               bitDone;

   TxState             state;
   logic [TIMER_W-1:0] bitTimer;
   logic [2:0]         bitIdx;
   logic [1:0]         byteIdx;
   logic [31:0]        shiftReg;

   // A word is only accepted when the registered count shows room, so a push that
   // coincides with a pop from a full FIFO is still dropped. Pops happen either from
   // IDLE or at the very end of the last stop bit, which keeps words back-to-back.
   assign fifoEmpty = (count == '0);
   assign bitDone   = (bitTimer == TIMER_LAST);
   assign pushNow   = bus.in_valid && (count != FULL_COUNT);
   assign popNow    = !fifoEmpty &&
                      ((state == IDLE) ||
                       ((state == STOP) && bitDone && (byteIdx == 2'd3)));

   assign bus.fifo_full = fifoFullReg;
   assign bus.overflow  = overflowReg;
   assign bus.busy      = !fifoEmpty || (state != IDLE);

   // Next occupancy: a simultaneous accepted push and pop leaves the count unchanged.
   always_comb begin
      countNext = count;
      case ({pushNow, popNow})
         2'b10:   countNext = count + (PTR_W + 1)'(1);
         2'b01:   countNext = count - (PTR_W + 1)'(1);
         default: countNext = count;
      endcase
   end

   // Word storage has no reset: after reset the count marks every entry as empty,
   // so stale contents can never be popped.
   always_ff @(posedge clk) begin
      if (pushNow) begin
         fifoMem[wrPtr] <= bus.in_data;
      end
   end

   // FIFO bookkeeping. Pointers wrap on their own width; the full flag is computed
   // from the next count so it is a clean register, and overflow is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         fifoFullReg <= 1'b0;
         overflowReg <= 1'b0;
      end else begin
         if (pushNow) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popNow) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         count       <= countNext;
         fifoFullReg <= (countNext == FULL_COUNT);
         if (bus.in_valid && (count == FULL_COUNT)) begin
            overflowReg <= 1'b1;
         end
      end
   end

   // Serialiser. The line value for the next bit period is registered on the same edge
   // that changes state, so tx never glitches. Data bits are taken from bit 0 of a
   // right-shifting word register; after eight shifts the next byte is already in
   // place, which is why no separate byte select is needed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bitTimer <= '0;
         bitIdx   <= '0;
         byteIdx  <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bitTimer <= '0;
               tx       <= 1'b1;
               if (popNow) begin
                  shiftReg <= fifoMem[rdPtr];
                  byteIdx  <= '0;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end

            START: begin
               if (bitDone) begin
                  bitTimer <= '0;
                  bitIdx   <= '0;
                  tx       <= shiftReg[0];
                  shiftReg <= {1'b0, shiftReg[31:1]};
                  state    <= DATA;
               end else begin
                  bitTimer <= bitTimer + TIMER_W'(1);
               end
            end

            DATA: begin
               if (bitDone) begin
                  bitTimer <= '0;
                  if (bitIdx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx   <= bitIdx + 3'd1;
                     tx       <= shiftReg[0];
                     shiftReg <= {1'b0, shiftReg[31:1]};
                  end
               end else begin
                  bitTimer <= bitTimer + TIMER_W'(1);
               end
            end

            STOP: begin
               if (bitDone) begin
                  bitTimer <= '0;
                  if (byteIdx != 2'd3) begin
                     byteIdx <= byteIdx + 2'd1;
                     tx      <= 1'b0;
                     state   <= START;
                  end else if (popNow) begin
                     shiftReg <= fifoMem[rdPtr];
                     byteIdx  <= '0;
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  bitTimer <= bitTimer + TIMER_W'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out32bit_uart_tx.sv
// Bench for out32bit_uart_tx: a queue-based line model predicts every output each cycle,
// and hand-computed latencies and decoded bytes pin that model to the intended behaviour.
module tb_out32bit_uart_tx;

   localparam int CPB     = 4;
   localparam int DEPTH   = 4;
   localparam int LOG_MAX = 8192;

   logic clk;
   logic reset;
   logic tx;

   int checks = 0;
   int errors = 0;
   int cycNum = 0;

   logic        txLog   [LOG_MAX];
   logic        busyLog [LOG_MAX];

   logic [31:0] modelFifo[$];
   bit          modelLine[$];
   bit          modelOverflow = 1'b0;

   logic [7:0]  decBytes[$];
   int          decStarts[$];
   int          decBadStops;
   logic [7:0]  expBytes[$];

   out32bit_uart_tx_if busIf ();

   out32bit_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf.slave),
      .tx    (tx)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index used for logging and relative timing.
   always @(posedge clk) begin
      cycNum <= cycNum + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // A word on the line is forty bit periods: per byte a low start, eight data bits
   // LSB-first and a high stop, each held for CPB cycles.
   task automatic expandWord(input logic [31:0] w);
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         for (int r = 0; r < CPB; r++) modelLine.push_back(1'b0);
         for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < CPB; r++) modelLine.push_back(b[i]);
         end
         for (int r = 0; r < CPB; r++) modelLine.push_back(1'b1);
      end
   endtask

   // One clock of the model: the line consumes a sample, an empty line pulls the next
   // buffered word, then the incoming word is accepted unless the buffer was full.
   task automatic modelStep(input logic v, input logic [31:0] d);
      bit wasFull;
      wasFull = (modelFifo.size() == DEPTH);
      if (modelLine.size() > 0) void'(modelLine.pop_front());
      if (modelLine.size() == 0 && modelFifo.size() > 0) expandWord(modelFifo.pop_front());
      if (v) begin
         if (wasFull) modelOverflow = 1'b1;
         else modelFifo.push_back(d);
      end
   endtask

   function automatic logic [3:0] modelOutputs();
      logic mTx;
      mTx = (modelLine.size() > 0) ? modelLine[0] : 1'b1;
      return {mTx, (modelLine.size() > 0) || (modelFifo.size() > 0),
              modelFifo.size() == DEPTH, modelOverflow};
   endfunction

   // Model advances on the same edges as the design; reset clears it immediately.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            modelFifo.delete();
            modelLine.delete();
            modelOverflow = 1'b0;
         end else begin
            modelStep(busIf.in_valid, busIf.in_data);
         end
      end
   end

   // Every falling edge: log the line and compare all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cycNum < LOG_MAX) begin
            txLog[cycNum]   = tx;
            busyLog[cycNum] = busIf.busy;
         end
         checkOutput($sformatf("cycle %0d {tx,busy,full,ovf}", cycNum),
                     {28'd0, tx, busIf.busy, busIf.fifo_full, busIf.overflow},
                     {28'd0, modelOutputs()});
      end
   end

   task automatic applyStimulus(input logic v, input logic [31:0] d);
      busIf.in_valid = v;
      busIf.in_data  = d;
      @(negedge clk);
      busIf.in_valid = 1'b0;
   endtask

   task automatic waitUntil(input int target);
      if (target > cycNum) repeat (target - cycNum) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   function automatic int firstTxLow(input int from);
      for (int i = from; i < cycNum && i < LOG_MAX; i++) begin
         if (txLog[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   function automatic int firstBusyLow(input int from);
      for (int i = from; i < cycNum && i < LOG_MAX; i++) begin
         if (busyLog[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   // Independent UART receiver working on the logged line: find each start bit and
   // sample every bit period in its middle.
   task automatic decodeLine(input int fromIdx, input int nBytes);
      int idx;
      logic [7:0] b;
      decBytes.delete();
      decStarts.delete();
      decBadStops = 0;
      idx = fromIdx;
      for (int n = 0; n < nBytes; n++) begin
         while (idx < cycNum && idx < LOG_MAX - 10*CPB && txLog[idx] !== 1'b0) idx++;
         if (idx >= cycNum || idx >= LOG_MAX - 10*CPB) break;
         for (int i = 0; i < 8; i++) b[i] = txLog[idx + CPB*(1+i) + CPB/2];
         if (txLog[idx + 9*CPB + CPB/2] !== 1'b1) decBadStops++;
         decBytes.push_back(b);
         decStarts.push_back(idx);
         idx += 10*CPB;
      end
   endtask

   task automatic checkDecoded(input string tag);
      logic [31:0] got;
      checkOutput({tag, " byte count"}, decBytes.size(), expBytes.size());
      checkOutput({tag, " bad stop bits"}, decBadStops, 0);
      for (int i = 0; i < expBytes.size(); i++) begin
         got = (i < decBytes.size()) ? {24'd0, decBytes[i]} : 32'hFFFF_FFFF;
         checkOutput($sformatf("%s byte %0d", tag, i), got, {24'd0, expBytes[i]});
      end
   endtask

   task automatic addWordBytes(input logic [31:0] w);
      for (int k = 0; k < 4; k++) expBytes.push_back(w[8*k +: 8]);
   endtask

   // Directed scenarios.
   initial begin
      int k;
      int fall;
      int busyFall;
      int rel;
      int zeros;
      int maxGap;
      logic [31:0] w;

      reset          = 1'b0;
      busIf.in_valid = 1'b0;
      busIf.in_data  = '0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset state {tx,busy,full,ovf}",
                  {28'd0, tx, busIf.busy, busIf.fifo_full, busIf.overflow}, 32'h8);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] reset mid-frame");
      k = cycNum;
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, i);
      checkOutput("T1 overflow set before reset", busIf.overflow, 1);
      waitUntil(k + 20);
      checkOutput("T1 tx low mid data", tx, 0);
      #2 reset = 1'b1;
      #1;
      checkOutput("T1 async reset {tx,busy,full,ovf}",
                  {28'd0, tx, busIf.busy, busIf.fifo_full, busIf.overflow}, 32'h8);
      @(negedge clk);
      reset = 1'b0;
      rel = cycNum;
      repeat (100) @(negedge clk);
      zeros = 0;
      for (int i = rel; i < cycNum; i++) if (txLog[i] !== 1'b1) zeros++;
      checkOutput("T1 line quiet after reset", zeros, 0);

      $display("[TB] single word");
      doReset();
      k = cycNum;
      applyStimulus(1'b1, 32'hA5C3_0F81);
      waitUntil(k + 200);
      fall = firstTxLow(k);
      checkOutput("T2 tx fall latency", fall - k, 2);
      busyFall = firstBusyLow(k + 1);
      checkOutput("T2 busy fall cycle", busyFall - k, 162);
      decodeLine(k, 4);
      expBytes = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
      checkDecoded("T2");

      $display("[TB] back-to-back words");
      doReset();
      k = cycNum;
      applyStimulus(1'b1, 32'h1122_3344);
      applyStimulus(1'b1, 32'h5566_7788);
      waitUntil(k + 360);
      fall = firstTxLow(k);
      busyFall = firstBusyLow(fall);
      checkOutput("T3 line cycles for two words", busyFall - fall, 320);
      decodeLine(k, 8);
      expBytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      checkDecoded("T3");
      maxGap = 0;
      for (int i = 1; i < decStarts.size(); i++) begin
         if (decStarts[i] - decStarts[i-1] > maxGap) maxGap = decStarts[i] - decStarts[i-1];
      end
      checkOutput("T3 max frame spacing", maxGap, 10*CPB);

      $display("[TB] overflow");
      doReset();
      k = cycNum;
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i);
      checkOutput("T4 full after 5th push", busIf.fifo_full, 1);
      checkOutput("T4 overflow before 6th push", busIf.overflow, 0);
      applyStimulus(1'b1, 32'd6);
      checkOutput("T4 overflow after 6th push", busIf.overflow, 1);
      waitUntil(k + 5*40*CPB + 40);
      decodeLine(k, 20);
      expBytes.delete();
      for (int i = 1; i <= 5; i++) addWordBytes(i);
      checkDecoded("T4");
      checkOutput("T4 overflow sticky", busIf.overflow, 1);
      checkOutput("T4 idle at end", busIf.busy, 0);

      $display("[TB] full and pop coincident");
      doReset();
      k = cycNum;
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'hC0DE_0000 + i);
      waitUntil(k + 161);
      checkOutput("T5 full before pulse", busIf.fifo_full, 1);
      applyStimulus(1'b1, 32'hBAD0_BAD0);
      checkOutput("T5 overflow after coincident push", busIf.overflow, 1);
      checkOutput("T5 full cleared by pop", busIf.fifo_full, 0);
      waitUntil(k + 5*40*CPB + 40);
      decodeLine(k, 20);
      expBytes.delete();
      for (int i = 1; i <= 5; i++) addWordBytes(32'hC0DE_0000 + i);
      checkDecoded("T5");

      $display("[TB] pointer wrap");
      doReset();
      k = cycNum;
      expBytes.delete();
      for (int i = 0; i < 12; i++) begin
         w = 32'h0246_8ACE + i * 32'h1357_9BDF;
         addWordBytes(w);
         applyStimulus(1'b1, w);
         repeat (139) @(negedge clk);
      end
      waitUntil(k + 1960);
      decodeLine(k, 48);
      checkDecoded("T6");
      checkOutput("T6 no overflow", busIf.overflow, 0);
      checkOutput("T6 idle at end", busIf.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
